// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the RV32I fetch stage.
//   fetch_state_e    : fetch FSM state encoding (issue / wait / drain / fault)
//   InstNop          : canonical NOP (addi x0, x0, 0) shown on an empty buffer after reset
//   AddrWDefault     : default PC / instruction-memory address width
//   is_word_aligned  : true when the two low PC bits are zero
package instruction_fetch_pkg;

  localparam int unsigned AddrWDefault = 32;
  localparam logic [31:0] InstNop      = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIssue = 2'd0,
    StWait  = 2'd1,
    StDrain = 2'd2,
    StFault = 2'd3
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_buffer.sv
// One-entry valid/ready buffer holding {inst, inst_pc} for the decoder.
//   clk, resetb            : clock, synchronous active-low reset
//   load, load_inst/pc     : write a freshly fetched instruction (buffer is empty when this fires)
//   flush                  : drop the held instruction; wins over load
//   out_valid/out_ready    : downstream handshake; transfer on out_valid & out_ready
//   out_inst, out_pc       : held instruction and its PC, stable while stalled
module instruction_fetch_buffer
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AddrWDefault,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetb,
  input  logic              load,
  input  logic [31:0]       load_inst,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              flush,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc
);

  logic              valid_q;
  logic [31:0]       inst_q;
  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      valid_q <= 1'b0;
      inst_q  <= InstNop;
      pc_q    <= RESET_PC;
    end else if (flush) begin
      // Payload is left as-is; only the valid bit matters once flushed.
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
      inst_q  <= load_inst;
      pc_q    <= load_pc;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_inst  = inst_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage of the RV32I softcore, feeding instruction_decoder.
// Holds the PC, issues single-outstanding word reads to instruction memory and hands
// {inst, inst_pc} to the decoder through a one-entry valid/ready buffer. Redirects from the
// branch/jump unit override everything; an in-flight read from the old path is drained and
// its data dropped.
//   clk, resetb                 : clock, synchronous active-low reset
//   imem_req, imem_addr         : read strobe and word address (the PC)
//   imem_rvalid, imem_rdata     : read response, >= 1 cycle after imem_req
//   redirect_valid, redirect_pc : load a new PC
//   inst_valid/ready, inst, inst_pc : decoder handshake and payload
//   fetch_misaligned            : last redirect target was not word aligned (sticky)
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = AddrWDefault,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetb,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_misaligned
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              misaligned_q;
  logic              buf_load;
  logic              buf_drain;

  assign buf_drain = inst_valid & inst_ready;

  // Issue when the buffer is empty or emptying this cycle, so a draining slot refills
  // without a bubble. Gated by resetb so no request escapes while reset is held.
  assign imem_req = resetb & (state_q == StIssue) & ~redirect_valid &
                    (~inst_valid | buf_drain);

  // A redirect in the same cycle as the response makes that response stale.
  assign buf_load = (state_q == StWait) & imem_rvalid & ~redirect_valid;

  assign imem_addr        = pc_q;
  assign fetch_misaligned = misaligned_q;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      state_q      <= StIssue;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      pc_q <= redirect_pc;
      if (!is_word_aligned(redirect_pc[1:0])) begin
        state_q      <= StFault;
        misaligned_q <= 1'b1;
      end else begin
        misaligned_q <= 1'b0;
        // A response landing this very cycle closes the old request; otherwise drain it.
        if ((state_q == StWait || state_q == StDrain) && !imem_rvalid) begin
          state_q <= StDrain;
        end else begin
          state_q <= StIssue;
        end
      end
    end else begin
      unique case (state_q)
        StIssue: begin
          if (imem_req) state_q <= StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            pc_q    <= pc_q + ADDR_W'(4);
            state_q <= StIssue;
          end
        end
        StDrain: begin
          if (imem_rvalid) state_q <= StIssue;
        end
        StFault: ;
      endcase
    end
  end

  instruction_fetch_buffer #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_buffer (
    .clk       (clk),
    .resetb    (resetb),
    .load      (buf_load),
    .load_inst (imem_rdata),
    .load_pc   (pc_q),
    .flush     (redirect_valid),
    .out_ready (inst_ready),
    .out_valid (inst_valid),
    .out_inst  (inst),
    .out_pc    (inst_pc)
  );

  // Stray read data is dropped, but it points at a memory-side protocol problem.
  always_ff @(posedge clk) begin
    if (resetb && imem_rvalid) begin
      assert (state_q == StWait || state_q == StDrain)
        else $warning("imem_rvalid with no request outstanding (state %0d)", state_q);
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  logic        clk;
  logic        resetb;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_misaligned;

  int vectors;
  int miscompares;

  instruction_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .resetb           (resetb),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .fetch_misaligned (fetch_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in its first post-reset cycle (ISSUE, empty buffer).
  task automatic do_reset();
    resetb         = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    step();
    step();
    resetb = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    resetb         = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    step();
    step();
    vectors++; if (imem_req !== 1'b0) begin miscompares++;
      $display("FAIL reset_req: imem_req=%b want 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++;
      $display("FAIL reset_addr: imem_addr=%h want 00000000", imem_addr); end
    vectors++; if (inst_valid !== 1'b0) begin miscompares++;
      $display("FAIL reset_valid: inst_valid=%b want 0", inst_valid); end
    vectors++; if (inst !== 32'h0000_0013) begin miscompares++;
      $display("FAIL reset_inst: inst=%h want 00000013", inst); end
    vectors++; if (inst_pc !== 32'h0) begin miscompares++;
      $display("FAIL reset_inst_pc: inst_pc=%h want 00000000", inst_pc); end
    vectors++; if (fetch_misaligned !== 1'b0) begin miscompares++;
      $display("FAIL reset_misaligned: fetch_misaligned=%b want 0", fetch_misaligned); end
  endtask

  // 1-cycle memory, decoder always ready.
  task automatic test_basic_fetch();
    do_reset();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++;
      $display("FAIL basic_first_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0010_0093;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++;
      $display("FAIL basic_wait_req: imem_req=%b want 0", imem_req); end
    step();
    imem_rvalid = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || inst !== 32'h0010_0093 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL basic_inst: valid=%b inst=%h pc=%h want 1/00100093/00000000",
               inst_valid, inst, inst_pc); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin miscompares++;
      $display("FAIL basic_next_req: req=%b addr=%h want 1/00000004", imem_req, imem_addr); end
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0020_0113;
    step();
    imem_rvalid = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || inst !== 32'h0020_0113 || inst_pc !== 32'h4) begin
      miscompares++;
      $display("FAIL basic_second: valid=%b inst=%h pc=%h want 1/00200113/00000004",
               inst_valid, inst, inst_pc); end
    vectors++; if (imem_addr !== 32'h8) begin miscompares++;
      $display("FAIL basic_third_addr: imem_addr=%h want 00000008", imem_addr); end
  endtask

  task automatic test_backpressure();
    do_reset();
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0030_0193;
    step();
    imem_rvalid = 1'b0;
    inst_ready  = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin miscompares++;
      $display("FAIL bp_stall_start: valid=%b req=%b want 1/0", inst_valid, imem_req); end
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (inst_valid !== 1'b1 || inst !== 32'h0030_0193 || inst_pc !== 32'h0 ||
          imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: valid=%b inst=%h pc=%h req=%b want 1/00300193/0/0",
                 i, inst_valid, inst, inst_pc, imem_req);
      end
    end
    inst_ready = 1'b1;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin miscompares++;
      $display("FAIL bp_release: req=%b addr=%h want 1/00000004", imem_req, imem_addr); end
    step();
  endtask

  // 3-cycle memory: request in C0, response in C3.
  task automatic test_redirect_wait();
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    step();
    redirect_valid = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin miscompares++;
      $display("FAIL rw_drain: req=%b valid=%b want 0/0", imem_req, inst_valid); end
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b0) begin miscompares++;
      $display("FAIL rw_stale_dropped: inst_valid=%b want 0", inst_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++;
      $display("FAIL rw_new_req: req=%b addr=%h want 1/00000100", imem_req, imem_addr); end
    step();
    vectors++; if (inst_valid !== 1'b0) begin miscompares++;
      $display("FAIL rw_no_old_inst: inst_valid=%b want 0", inst_valid); end
  endtask

  task automatic test_redirect_collide();
    do_reset();
    step();
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h1234_5678;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      miscompares++;
      $display("FAIL collide: valid=%b req=%b addr=%h want 0/1/00000040",
               inst_valid, imem_req, imem_addr); end
  endtask

  task automatic test_misaligned();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++;
      $display("FAIL mis_suppress: imem_req=%b want 0", imem_req); end
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL mis_fault[%0d]: flag=%b req=%b valid=%b want 1/0/0",
                 i, fetch_misaligned, imem_req, inst_valid);
      end
      step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    #1;
    vectors++; if (fetch_misaligned !== 1'b0) begin miscompares++;
      $display("FAIL mis_clear: fetch_misaligned=%b want 0", fetch_misaligned); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin miscompares++;
      $display("FAIL mis_refetch: req=%b addr=%h want 1/00000200", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin miscompares++;
      $display("FAIL wrap_req: req=%b addr=%h want 1/fffffffc", imem_req, imem_addr); end
    step();
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0073;
    step();
    imem_rvalid = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin miscompares++;
      $display("FAIL wrap_inst: valid=%b pc=%h want 1/fffffffc", inst_valid, inst_pc); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++;
      $display("FAIL wrap_next: req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    redirect_valid = 1'b0;
    step();
    // Now in WAIT for 0x80; pull reset before the response.
    resetb = 1'b0;
    step();
    resetb      = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_BAD0;
    #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++;
      $display("FAIL rst_mid_req: req=%b addr=%h want 1/00000000", imem_req, imem_addr); end
    step();
    vectors++; if (inst_valid !== 1'b0) begin miscompares++;
      $display("FAIL rst_mid_ignored: inst_valid=%b want 0", inst_valid); end
    imem_rdata = 32'h0040_0213;
    step();
    imem_rvalid = 1'b0;
    #1;
    vectors++; if (inst_valid !== 1'b1 || inst !== 32'h0040_0213 || inst_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid_fetch: valid=%b inst=%h pc=%h want 1/00400213/00000000",
               inst_valid, inst, inst_pc); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_collide();
    test_misaligned();
    test_wrap();
    test_reset_mid_fetch();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
